// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes,
// FSM states and small op-decode helpers.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MULTU = 3'b000,
      OP_MULT  = 3'b001,
      OP_DIVU  = 3'b010,
      OP_DIV   = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101,
      OP_NOP6  = 3'b110,
      OP_NOP7  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   // Multi-cycle ops are the four with op[2] clear.
   function automatic logic is_muldiv(input logic [2:0] i_op);
      return (i_op[2] == 1'b0);
   endfunction

   // Single-cycle register moves.
   function automatic logic is_move(input logic [2:0] i_op);
      return (i_op == OP_MTHI) || (i_op == OP_MTLO);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the shared multiply/divide datapath.
// Multiply: conditional add of the multiplicand into the upper half, then
// shift the {acc, mq} pair right by one.
// Divide: shift {acc, mq} left by one, trial-subtract the divisor from the
// partial remainder, and shift the quotient bit into mq.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0] i_mq,
   input  logic [WIDTH-1:0] i_opnd,
   output logic [WIDTH-1:0] o_acc,
   output logic [WIDTH-1:0] o_mq
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shifted;
   logic [WIDTH-1:0] w_addend;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;

   // Compute both iteration flavours and select by operation class.
   always_comb begin
      w_addend  = i_mq[0] ? i_opnd : '0;
      w_sum     = {1'b0, i_acc} + {1'b0, w_addend};
      w_shifted = {i_acc, i_mq[WIDTH-1]};
      w_ge      = (w_shifted >= {1'b0, i_opnd});
      // When w_ge holds the true difference is below the divisor, so the
      // low WIDTH bits of the wrapped subtraction are exact.
      w_diff    = w_shifted[WIDTH-1:0] - i_opnd;
      if (i_is_div) begin
         o_acc = w_ge ? w_diff : w_shifted[WIDTH-1:0];
         o_mq  = {i_mq[WIDTH-2:0], w_ge};
      end else begin
         o_acc = w_sum[WIDTH:1];
         o_mq  = {w_sum[0], i_mq[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit. Signed operands are converted to
// magnitudes on accept, WIDTH unsigned radix-2 steps run in RUN, and the
// signs are restored in the single FIX cycle before HI/LO are written.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);

   state_e             r_state;
   state_e             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_mq;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_is_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_div0;
   logic               r_done;
   logic               r_div0_pulse;

   logic               w_accept_md;
   logic               w_accept_mv;
   logic               w_finish;
   logic               w_busy;
   logic               w_op_signed;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH-1:0]   w_step_acc;
   logic [WIDTH-1:0]   w_step_mq;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_is_div (r_is_div),
      .i_acc    (r_acc),
      .i_mq     (r_mq),
      .i_opnd   (r_opnd),
      .o_acc    (w_step_acc),
      .o_mq     (w_step_mq)
   );

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and control strobes. Flush wins over start and over the
   // final write-back.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned, which would otherwise infer a latch.
      w_next      = r_state;
      w_accept_md = 1'b0;
      w_accept_mv = 1'b0;
      w_finish    = 1'b0;
      w_busy      = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (start && !flush) begin
               if (is_muldiv(op)) begin
                  w_accept_md = 1'b1;
                  w_next      = ST_RUN;
               end else if (is_move(op)) begin
                  w_accept_mv = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (flush) begin
               w_next = ST_IDLE;
            end else if (r_cnt == CNT_W'(WIDTH - 1)) begin
               w_next = ST_FIX;
            end
         end
         ST_FIX: begin
            w_next   = ST_IDLE;
            w_finish = !flush;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Operand magnitudes for the unsigned core.
   always_comb begin
      w_op_signed = op[0];
      w_a_mag     = (w_op_signed && a[WIDTH-1]) ? -a : a;
      w_b_mag     = (w_op_signed && b[WIDTH-1]) ? -b : b;
   end

   // Sign correction and divide-by-zero override applied in FIX.
   always_comb begin
      w_prod   = r_neg_q ? -{r_acc, r_mq} : {r_acc, r_mq};
      w_quo    = r_neg_q ? -r_mq : r_mq;
      w_rem    = r_neg_r ? -r_acc : r_acc;
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
      if (r_is_div) begin
         if (r_div0) begin
            w_res_hi = r_a;
            w_res_lo = '1;
         end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
         end
      end
   end

   // Datapath, iteration counter and architectural HI/LO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt        <= '0;
         r_acc        <= '0;
         r_mq         <= '0;
         r_opnd       <= '0;
         r_a          <= '0;
         r_hi         <= '0;
         r_lo         <= '0;
         r_is_div     <= 1'b0;
         r_neg_q      <= 1'b0;
         r_neg_r      <= 1'b0;
         r_div0       <= 1'b0;
         r_done       <= 1'b0;
         r_div0_pulse <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         r_done       <= 1'b0;
         r_div0_pulse <= 1'b0;
         if (w_accept_md) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mq     <= w_a_mag;
            r_opnd   <= w_b_mag;
            r_a      <= a;
            r_is_div <= op[1];
            r_neg_q  <= w_op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r  <= w_op_signed && op[1] && a[WIDTH-1];
            r_div0   <= op[1] && (b == '0);
         end else if (r_state == ST_RUN) begin
            r_acc <= w_step_acc;
            r_mq  <= w_step_mq;
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_finish) begin
            r_hi         <= w_res_hi;
            r_lo         <= w_res_lo;
            r_done       <= 1'b1;
            r_div0_pulse <= r_div0;
         end
         if (w_accept_mv) begin
            if (op == OP_MTHI) begin
               r_hi <= a;
            end else begin
               r_lo <= a;
            end
         end
      end
   end

   assign busy = w_busy;
   assign done = r_done;
   assign div0 = r_div0_pulse;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a constant vector table, a set of
// random ops against a 64-bit reference model, and hand-written sequences
// for moves, start-while-busy, flush, and reset mid-operation.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         flush;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic         div0;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .div0  (div0),
      .hi    (hi),
      .lo    (lo)
   );

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         div0;
   } exp_t;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         div0;
   } vec_t;

   exp_t         exp_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   time          t_acc;
   logic [W-1:0] prev_hi;
   logic [W-1:0] prev_lo;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model built on 64-bit simulator arithmetic.
   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t        r;
      longint      sx;
      longint      sy;
      longint      sq;
      longint      sr;
      logic [63:0] p;
      sx = longint'(signed'(x));
      sy = longint'(signed'(y));
      r.div0 = 1'b0;
      r.hi   = '0;
      r.lo   = '0;
      if (o == 3'b000) begin
         p    = {32'b0, x} * {32'b0, y};
         r.hi = p[63:32];
         r.lo = p[31:0];
      end else if (o == 3'b001) begin
         p    = 64'(sx * sy);
         r.hi = p[63:32];
         r.lo = p[31:0];
      end else if (y == '0) begin
         r.hi   = x;
         r.lo   = '1;
         r.div0 = 1'b1;
      end else if (o == 3'b010) begin
         r.lo = x / y;
         r.hi = x % y;
      end else begin
         sq   = sx / sy;
         sr   = sx % sy;
         r.lo = sq[31:0];
         r.hi = sr[31:0];
      end
      return r;
   endfunction

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      prev_hi = hi;
      prev_lo = lo;
      start   = 1'b1;
      op      = o;
      a       = x;
      b       = y;
      @(posedge clk);
      t_acc = $time;
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int  cycles;
      bit  busy_ok;
      bit  hold_ok;
      time lat;
      exp_t e;
      cycles  = 0;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      while (done !== 1'b1 && cycles < 200) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
         @(posedge clk);
         #1;
         cycles++;
      end
      lat = ($time - t_acc) / 10;
      check({name, " latency"}, 64'(lat), 64'(LAT));
      check({name, " busy during run"}, 64'(busy_ok), 64'(1));
      check({name, " hi/lo held"}, 64'(hold_ok), 64'(1));
      check({name, " busy at done"}, 64'(busy), 64'(0));
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s scoreboard: got result expected none queued", name);
      end else begin
         e = exp_q.pop_front();
         check({name, " hi"}, 64'(hi), 64'(e.hi));
         check({name, " lo"}, 64'(lo), 64'(e.lo));
         check({name, " div0"}, 64'(div0), 64'(e.div0));
      end
      @(posedge clk);
      #1;
      check({name, " done pulse"}, 64'(done), 64'(0));
   endtask

   task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input exp_t e);
      exp_q.push_back(e);
      issue(o, x, y);
      wait_done(name);
   endtask

   // Idle for n cycles, confirming no done/busy appears and HI/LO stay put.
   task automatic watch_idle(input string name, input int n, input logic [W-1:0] eh, input logic [W-1:0] el);
      int n_done;
      int n_busy;
      n_done = 0;
      n_busy = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) n_done++;
         if (busy === 1'b1) n_busy++;
      end
      check({name, " done count"}, 64'(n_done), 64'(0));
      check({name, " busy count"}, 64'(n_busy), 64'(0));
      check({name, " hi"}, 64'(hi), 64'(eh));
      check({name, " lo"}, 64'(lo), 64'(el));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t     vecs[13];
      exp_t     e;
      logic [2:0]   ro;
      logic [W-1:0] rx;
      logic [W-1:0] ry;

      vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3]  = '{OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
      vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[5]  = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
      vecs[6]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
      vecs[7]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
      vecs[8]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      vecs[9]  = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
      vecs[10] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
      vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vecs[12] = '{OP_MULTU, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 1'b0};

      reset = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = 3'b000;
      a     = '0;
      b     = '0;

      // Reset state.
      #12;
      check("reset hi", 64'(hi), 64'(0));
      check("reset lo", 64'(lo), 64'(0));
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset div0", 64'(div0), 64'(0));

      // MTLO accepted on the first edge after reset release.
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      op    = OP_MTLO;
      a     = 32'h0000_1234;
      @(posedge clk);
      #1 start = 1'b0;
      check("mtlo lo", 64'(lo), 64'(32'h1234));
      check("mtlo hi", 64'(hi), 64'(0));
      check("mtlo busy", 64'(busy), 64'(0));
      check("mtlo done", 64'(done), 64'(0));

      issue(OP_MTHI, 32'h0000_CAFE, 32'h0);
      check("mthi hi", 64'(hi), 64'(32'hCAFE));
      check("mthi lo", 64'(lo), 64'(32'h1234));
      check("mthi busy", 64'(busy), 64'(0));
      check("mthi done", 64'(done), 64'(0));

      // Reserved op codes do nothing.
      issue(3'b110, 32'h5555_5555, 32'h6666_6666);
      watch_idle("nop6", 3, 32'hCAFE, 32'h1234);
      issue(3'b111, 32'h5555_5555, 32'h6666_6666);
      watch_idle("nop7", 3, 32'hCAFE, 32'h1234);

      // Directed vector table.
      for (int i = 0; i < 13; i++) begin
         e = '{vecs[i].hi, vecs[i].lo, vecs[i].div0};
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, e);
      end

      // Random ops against the reference model; some small divisors incl. 0.
      for (int i = 0; i < 16; i++) begin
         ro = 3'($urandom_range(0, 3));
         rx = $urandom;
         ry = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         run_op($sformatf("rnd%0d", i), ro, rx, ry, model(ro, rx, ry));
      end

      // Start (an MTLO) while busy must be ignored.
      exp_q.push_back('{32'h0, 32'd42, 1'b0});
      issue(OP_MULTU, 32'd6, 32'd7);
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      op    = OP_MTLO;
      a     = 32'hDEAD_0000;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("busy_ignore");
      watch_idle("busy_ignore after", 3, 32'h0, 32'd42);

      // Flush during the tenth RUN cycle.
      issue(OP_MULTU, 32'd3, 32'd5);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush busy", 64'(busy), 64'(0));
      watch_idle("flush", 40, 32'h0, 32'd42);

      // Flush together with start drops the start.
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      op    = OP_MULTU;
      a     = 32'd2;
      b     = 32'd2;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      check("flush+start busy", 64'(busy), 64'(0));
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      op    = OP_MTLO;
      a     = 32'hBEEF;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      watch_idle("flush+start", 40, 32'h0, 32'd42);

      // Reset asserted in the middle of RUN.
      run_op("pre_reset", OP_DIVU, 32'd100, 32'd7, '{32'd2, 32'd14, 1'b0});
      issue(OP_MULT, 32'h1111_1111, 32'd3);
      repeat (10) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("midrun reset hi", 64'(hi), 64'(0));
      check("midrun reset lo", 64'(lo), 64'(0));
      check("midrun reset busy", 64'(busy), 64'(0));
      check("midrun reset done", 64'(done), 64'(0));
      check("midrun reset div0", 64'(div0), 64'(0));
      @(negedge clk);
      reset = 1'b1;
      watch_idle("after reset", 40, 32'h0, 32'h0);

      run_op("post_reset", OP_MULTU, 32'h0001_0000, 32'h0001_0000, '{32'h1, 32'h0, 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
